// File: rtl/mem_access_sequencer_pkg.sv
// Shared LC-3b types for the MEM-stage sequencer: FSM state encoding and
// default word/address typedefs.
package mem_access_sequencer_pkg;

  localparam int unsigned LC3B_DATA_W = 16;
  localparam int unsigned LC3B_ADDR_W = 16;

  typedef logic [LC3B_DATA_W-1:0] lc3b_word;
  typedef logic [LC3B_ADDR_W-1:0] lc3b_addr;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_PTR  = 2'd1,
    MS_ACC  = 2'd2
  } mem_seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//  clk, rst : clock, synchronous active-high reset
//  inc      : count up by one (ignored once at all-ones)
//  clr      : synchronous clear, wins over inc
//  count    : current value
//  at_max   : count is all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && !at_max) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count  = r_count;
  assign at_max = &r_count;

endmodule

// File: rtl/mem_access_sequencer.sv
// LC-3b MEM-stage sequencer: runs LD/ST/LDB/STB and the two-access LDI/STI
// over a request/response L1 handshake, stalls the upstream pipeline while an
// access is outstanding, counts stalled cycles and flags unresponsive memory.
//  clk, rst               : clock, synchronous active-high reset
//  valid_in, in_mem       : EX/MEM holds a valid memory instruction
//  in_st/in_indirect/in_byte : store, LDI/STI pointer fetch, byte access
//  addr_in, wdata_in      : effective address and store data
//  mem_resp, mem_rdata    : L1 one-cycle response and read data
//  mem_read/mem_write/mem_address/mem_wdata/mem_byte_enable : L1 request
//  stage_enable, bubble_out : pipeline register enables, MEM/WB NOP insert
//  mem_done, busy         : final access done this cycle, sequencer active
//  timeout_err, stall_count : sticky watchdog flag, saturating stall counter
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned MEM_IDX    = 2,
  parameter int unsigned MAX_WAIT   = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic                    in_mem,
  input  logic                    in_st,
  input  logic                    in_indirect,
  input  logic                    in_byte,
  input  logic [ADDR_W-1:0]       addr_in,
  input  logic [DATA_W-1:0]       wdata_in,
  input  logic                    mem_resp,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_W-1:0]       mem_address,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic [DATA_W/8-1:0]     mem_byte_enable,
  output logic [NUM_STAGES-1:0]   stage_enable,
  output logic                    bubble_out,
  output logic                    mem_done,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [CNT_W-1:0]        stall_count
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = (BE_W > 1) ? $clog2(BE_W) : 1;
  localparam int unsigned WD_W   = $clog2(MAX_WAIT);
  // Stalled pattern: EX/MEM and everything upstream hold, later registers load.
  localparam logic [NUM_STAGES-1:0] STALL_MASK = {NUM_STAGES{1'b1}} << (MEM_IDX + 1);

  mem_seq_state_t    r_state;
  mem_seq_state_t    w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_timeout;
  logic              w_stall;
  logic              w_req;
  logic              w_wd_hit;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [WD_W-1:0]   w_wd_cnt;
  logic              w_wd_at_max;
  logic              w_stall_at_max;

  // State, pointer capture and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= MS_IDLE;
      r_ptr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == MS_PTR && mem_resp) begin
        r_ptr <= ADDR_W'(mem_rdata);
      end
      if (w_wd_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign w_acc_addr = in_indirect ? r_ptr : addr_in;

  // Next state, request drive and stall decision.
  always_comb begin
    w_state_next    = r_state;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = addr_in;
    mem_byte_enable = '1;
    mem_done        = 1'b0;
    w_stall         = 1'b0;
    case (r_state)
      MS_IDLE: begin
        // Decode cycle: request goes out next cycle, upstream already held.
        if (valid_in && in_mem) begin
          w_stall      = 1'b1;
          w_state_next = in_indirect ? MS_PTR : MS_ACC;
        end
      end
      MS_PTR: begin
        mem_read = 1'b1;
        w_stall  = 1'b1;
        if (mem_resp) begin
          w_state_next = MS_ACC;
        end
      end
      MS_ACC: begin
        mem_read    = ~in_st;
        mem_write   = in_st;
        mem_address = w_acc_addr;
        if (in_byte) begin
          mem_byte_enable = (BE_W > 1) ? (BE_W'(1) << w_acc_addr[LANE_W-1:0]) : '1;
        end
        // Completing cycle is not a stall so MEM/WB loads mem_rdata directly.
        if (mem_resp) begin
          mem_done     = 1'b1;
          w_state_next = MS_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_next = MS_IDLE;
      end
    endcase
  end

  assign w_req    = (r_state != MS_IDLE);
  assign w_wd_hit = w_req && !mem_resp && (w_wd_cnt == WD_W'(MAX_WAIT - 1));

  // Per-access wait counter; cleared outside accesses and on every response.
  sat_counter #(
    .CNT_W (WD_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_req && !w_wd_at_max),
    .clr    (!w_req || mem_resp),
    .count  (w_wd_cnt),
    .at_max (w_wd_at_max)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (w_stall && !w_stall_at_max),
    .clr    (1'b0),
    .count  (stall_count),
    .at_max (w_stall_at_max)
  );

  assign mem_wdata    = wdata_in;
  assign stage_enable = w_stall ? STALL_MASK : {NUM_STAGES{1'b1}};
  assign bubble_out   = w_stall;
  assign busy         = w_req;
  assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed scenarios, an IDLE-decode vector
// table, and randomized traffic against a queue-based reference model.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, in_mem, in_st, in_indirect, in_byte;
  logic [15:0] addr_in, wdata_in, mem_rdata;
  logic        mem_resp;
  logic        mem_read, mem_write;
  logic [15:0] mem_address, mem_wdata;
  logic [1:0]  mem_byte_enable;
  logic [3:0]  stage_enable;
  logic        bubble_out, mem_done, busy, timeout_err;
  logic [31:0] stall_count;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .in_mem          (in_mem),
    .in_st           (in_st),
    .in_indirect     (in_indirect),
    .in_byte         (in_byte),
    .addr_in         (addr_in),
    .wdata_in        (wdata_in),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .stage_enable    (stage_enable),
    .bubble_out      (bubble_out),
    .mem_done        (mem_done),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_cyc(input string nm, input logic rd, input logic wr,
                         input logic [15:0] ad, input logic [1:0] be,
                         input logic [3:0] se, input logic bub, input logic dn);
    chk({nm, "/ctl"}, 64'({mem_read, mem_write, stage_enable, bubble_out, mem_done}),
        64'({rd, wr, se, bub, dn}));
    if (rd || wr) begin
      chk({nm, "/addr"}, 64'(mem_address), 64'(ad));
      chk({nm, "/be"}, 64'(mem_byte_enable), 64'(be));
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
  endtask

  task automatic set_op(input logic v, input logic m, input logic st, input logic ind,
                        input logic b, input logic [15:0] a, input logic [15:0] wd);
    valid_in = v; in_mem = m; in_st = st; in_indirect = ind; in_byte = b;
    addr_in = a; wdata_in = wd;
  endtask

  typedef struct {
    logic       v, m, st, ind, b;
    logic [3:0] se;
    logic       bub;
  } vec_t;

  vec_t vt[7];

  // Reference model state: queue of accesses still to perform for the
  // current instruction (0 = pointer fetch, 1 = final data access).
  int          mq[$];
  logic [15:0] m_ptr;
  int          m_wait;
  bit          m_to;
  longint      m_stall;
  int          drought;

  initial begin
    rst = 1'b1;
    set_op(0, 0, 0, 0, 0, 16'h0, 16'h0);
    mem_resp = 1'b0; mem_rdata = 16'h0;
    nxt(); nxt();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk_cyc("reset", 0, 0, 0, 0, 4'b1111, 0, 0);
    chk("reset/busy", 64'(busy), 0);
    chk("reset/timeout", 64'(timeout_err), 0);
    chk("reset/stall_count", 64'(stall_count), 0);

    // LDR 0x3000, zero-wait response
    nxt(); set_op(1, 1, 0, 0, 0, 16'h3000, 16'h0);
    @(negedge clk); chk_cyc("ldr_dec", 0, 0, 0, 0, 4'b1000, 1, 0);
    nxt(); mem_resp = 1; mem_rdata = 16'h1234;
    @(negedge clk); chk_cyc("ldr_acc", 1, 0, 16'h3000, 2'b11, 4'b1111, 0, 1);
    nxt(); set_op(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); chk("ldr/busy", 64'(busy), 0);
    chk("ldr/stall_count", 64'(stall_count), 1);

    // LDI 0x4000 -> pointer 0x5002 -> 0xBEEF
    nxt(); set_op(1, 1, 0, 1, 0, 16'h4000, 16'h0);
    @(negedge clk); chk_cyc("ldi_dec", 0, 0, 0, 0, 4'b1000, 1, 0);
    nxt(); mem_resp = 1; mem_rdata = 16'h5002;
    @(negedge clk); chk_cyc("ldi_ptr", 1, 0, 16'h4000, 2'b11, 4'b1000, 1, 0);
    nxt(); mem_resp = 1; mem_rdata = 16'hBEEF;
    @(negedge clk); chk_cyc("ldi_acc", 1, 0, 16'h5002, 2'b11, 4'b1111, 0, 1);
    nxt(); set_op(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); chk("ldi/stall_count", 64'(stall_count), 3);

    // STB to odd then even byte
    for (int k = 0; k < 2; k++) begin
      nxt(); set_op(1, 1, 1, 0, 1, (k == 0) ? 16'h6001 : 16'h6000, 16'h00AB);
      @(negedge clk); chk_cyc("stb_dec", 0, 0, 0, 0, 4'b1000, 1, 0);
      nxt(); mem_resp = 1;
      @(negedge clk);
      chk_cyc("stb_acc", 0, 1, (k == 0) ? 16'h6001 : 16'h6000,
              (k == 0) ? 2'b10 : 2'b01, 4'b1111, 0, 1);
      chk("stb/wdata", 64'(mem_wdata), 64'h00AB);
    end
    nxt(); set_op(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); chk("stb/stall_count", 64'(stall_count), 5);

    // STI with 5-cycle response latency on both accesses
    nxt(); set_op(1, 1, 1, 1, 0, 16'h7000, 16'h5A5A);
    @(negedge clk); chk_cyc("sti_dec", 0, 0, 0, 0, 4'b1000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); if (i == 4) begin mem_resp = 1; mem_rdata = 16'h7102; end
      @(negedge clk); chk_cyc("sti_ptr", 1, 0, 16'h7000, 2'b11, 4'b1000, 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      nxt(); if (i == 4) mem_resp = 1;
      @(negedge clk);
      chk_cyc("sti_acc", 0, 1, 16'h7102, 2'b11, (i == 4) ? 4'b1111 : 4'b1000,
              (i != 4), (i == 4));
    end
    nxt(); set_op(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); chk("sti/stall_count", 64'(stall_count), 15);

    // Watchdog: 64 waiting cycles flag the error; late response still completes
    nxt(); set_op(1, 1, 0, 0, 0, 16'h8000, 16'h0);
    for (int i = 0; i <= 64; i++) begin
      nxt();
      @(negedge clk);
      chk("wd/timeout", 64'(timeout_err), (i == 64) ? 64'd1 : 64'd0);
      if (i == 0 || i == 64) chk_cyc("wd_wait", 1, 0, 16'h8000, 2'b11, 4'b1000, 1, 0);
    end
    nxt(); mem_resp = 1; mem_rdata = 16'h4242;
    @(negedge clk); chk_cyc("wd_late", 1, 0, 16'h8000, 2'b11, 4'b1111, 0, 1);
    nxt(); set_op(0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clk); chk("wd/sticky", 64'(timeout_err), 1);
    chk("wd/stall_count", 64'(stall_count), 81);

    // Reset in PTR, then a non-memory op in IDLE
    nxt(); set_op(1, 1, 0, 1, 0, 16'h9000, 16'h0);
    nxt();
    @(negedge clk); chk("rstptr/busy_before", 64'(busy), 1);
    nxt(); rst = 1;
    nxt(); rst = 0; set_op(1, 0, 0, 0, 0, 16'h1111, 16'h0);
    @(negedge clk);
    chk_cyc("rstptr_add", 0, 0, 0, 0, 4'b1111, 0, 0);
    chk("rstptr/busy", 64'(busy), 0);
    chk("rstptr/stall_count", 64'(stall_count), 0);
    chk("rstptr/timeout", 64'(timeout_err), 0);
    nxt();
    @(negedge clk); chk("add/busy", 64'(busy), 0);
    chk("add/stall_count", 64'(stall_count), 0);

    // IDLE decode table: only valid memory ops stall
    vt[0] = '{v:0, m:0, st:0, ind:0, b:0, se:4'b1111, bub:0};
    vt[1] = '{v:1, m:0, st:0, ind:0, b:0, se:4'b1111, bub:0};
    vt[2] = '{v:0, m:1, st:1, ind:1, b:1, se:4'b1111, bub:0};
    vt[3] = '{v:1, m:1, st:0, ind:0, b:0, se:4'b1000, bub:1};
    vt[4] = '{v:1, m:1, st:1, ind:1, b:1, se:4'b1000, bub:1};
    vt[5] = '{v:1, m:1, st:0, ind:1, b:0, se:4'b1000, bub:1};
    vt[6] = '{v:1, m:0, st:1, ind:1, b:1, se:4'b1111, bub:0};
    foreach (vt[i]) begin
      nxt(); rst = 0;
      set_op(vt[i].v, vt[i].m, vt[i].st, vt[i].ind, vt[i].b, 16'h2001, 16'h0);
      @(negedge clk);
      chk_cyc("table", 0, 0, 0, 0, vt[i].se, vt[i].bub, 0);
      chk("table/busy", 64'(busy), 0);
      nxt(); rst = 1;
      @(negedge clk);
      chk("table/next_busy", 64'(busy), 64'(vt[i].v & vt[i].m));
    end

    // Randomized traffic against the reference model
    nxt(); rst = 1; nxt(); rst = 0;
    mq.delete(); m_ptr = '0; m_wait = 0; m_to = 0; m_stall = 0; drought = 0;
    for (int c = 0; c < 4000; c++) begin
      bit          act, fin, e_rd, e_wr, e_done, e_stall;
      logic [15:0] e_addr;
      logic [1:0]  e_be;
      nxt();
      rst = ($urandom_range(0, 149) == 0);
      if (mq.size() == 0) begin
        set_op($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
               1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
      end
      if (drought == 0 && $urandom_range(0, 399) == 0) drought = 70;
      if (drought > 0) begin
        drought--;
        mem_resp = 0;
      end else begin
        mem_resp = ($urandom_range(0, 2) == 0);
      end
      mem_rdata = 16'($urandom);

      act = (mq.size() != 0);
      fin = act ? (mq[0] == 1) : 1'b0;
      e_rd    = act && (!fin || !in_st);
      e_wr    = fin && in_st;
      e_addr  = (fin && in_indirect) ? m_ptr : addr_in;
      e_be    = (fin && in_byte) ? (e_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      e_done  = fin && mem_resp;
      e_stall = act ? !(fin && mem_resp) : (valid_in && in_mem);

      @(negedge clk);
      chk_cyc("rand", e_rd, e_wr, e_addr, e_be, e_stall ? 4'b1000 : 4'b1111, e_stall, e_done);
      chk("rand/busy", 64'(busy), 64'(act));
      chk("rand/timeout", 64'(timeout_err), 64'(m_to));
      chk("rand/stall_count", 64'(stall_count), 64'(m_stall));
      chk("rand/wdata", 64'(mem_wdata), 64'(wdata_in));

      if (rst) begin
        mq.delete(); m_ptr = '0; m_wait = 0; m_to = 0; m_stall = 0;
      end else begin
        if (e_stall) m_stall++;
        if (!act) begin
          if (valid_in && in_mem) begin
            if (in_indirect) mq.push_back(0);
            mq.push_back(1);
            m_wait = 0;
          end
        end else if (mem_resp) begin
          if (mq[0] == 0) m_ptr = mem_rdata;
          void'(mq.pop_front());
          m_wait = 0;
        end else begin
          m_wait++;
          if (m_wait >= 64) m_to = 1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
